mem_arbiter: RTL and testbench
==============================

Name: mem_arbiter

Overview:
- Single-owner arbiter for the shared unified instruction/data memory of the multi-cycle RISC-V core.
- Serialises three requesters onto the one memory port:
  - port 0: instruction fetch (IR_Write path)
  - port 1: load/store (Mem_Write / load path)
  - port 2: debug/loader (preloads test arrays, reads back results)
- One transaction in flight at a time. Fixed-latency synchronous RAM behind it.

Parameters:
- AW, 32, address width per requester.
- DW, 32, data width.
- MEM_LAT, 1, RAM read latency in cycles from mem_en to valid mem_rdata; legal range 1..15, anything else is an elaboration error.

Ports:
- clk  in  1  system clock, all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- req  in  3  request per port, bit i = port i.
- we  in  3  write enable per port; 0 = read.
- addr  in  3*AW  port i address at bits [i*AW +: AW].
- wdata  in  3*DW  port i write data at bits [i*DW +: DW].
- gnt  out  3  one-hot, one-cycle pulse: request accepted.
- done  out  3  one-hot, one-cycle pulse: transaction complete.
- rdata  out  DW  read data, valid only while done[i] is high for a read.
- busy  out  1  high in any state other than IDLE.
- owner  out  2  current/last owner index.
- mem_en  out  1  RAM access strobe.
- mem_we  out  1  RAM write enable.
- mem_addr  out  AW  RAM address.
- mem_wdata  out  DW  RAM write data.
- mem_rdata  in  DW  RAM read data.

Behaviour:
- Interface: one clock (clk); reset rst is synchronous and active-high.
- Reset values: state=IDLE, gnt=0, done=0, rdata=0, busy=0, mem_en=0, mem_we=0, mem_addr=0, mem_wdata=0, owner=2 (round-robin pointer), latency counter=0.
- FSM:
  - IDLE: if any req bit is set, pick a winner by round-robin, searching from owner+1 mod 3. Latch the winner's we/addr/wdata and set owner=winner. Next state ACCESS. With no request, stay in IDLE.
  - ACCESS (exactly 1 cycle): mem_en=1, mem_we/addr/wdata from the latched values, gnt[owner]=1. Load counter=MEM_LAT. Next state WAIT.
  - WAIT: decrement counter each cycle. In the cycle the counter reaches 1, capture mem_rdata into rdata (reads only; writes leave rdata unchanged). Next state RESP.
  - RESP (1 cycle): done[owner]=1. Next state IDLE.
- Latency: req sampled in cycle t gives gnt in t+1 and done in t+2+MEM_LAT. Peak throughput is one transaction per MEM_LAT+3 cycles.
- Outside ACCESS, mem_en=0 and mem_we=0. mem_addr and mem_wdata hold their last value.
- Requester rules:
  - Hold req/we/addr/wdata stable until gnt.
  - Values may change freely after gnt.
  - req still high in the cycle after done is a new request.
  - Dropping req before gnt withdraws the request. A withdrawal that collides with the IDLE sampling edge still completes (gnt and done are issued).
- Fairness: with all three requesting continuously, the grant order is 0,1,2,0,1,2... A port waits at most 2 other transactions.
- Simultaneous events: req changes on non-owner ports during busy are ignored until IDLE. done and gnt are never high in the same cycle.
- rst asserted in any state: next edge goes to IDLE and all outputs take reset values. The in-flight transaction is dropped with no done. A write already strobed in ACCESS is not undone.

Optional Feature:
- ARB_DEBUG_PRIO_EN
  - Defined: port 2 has absolute priority. Whenever req[2]=1 in IDLE, port 2 wins. A debug grant does not update the round-robin pointer; ports 0/1 round-robin between themselves using a separate pointer.
  - Undefined: pure 3-way round-robin as above.
- Port list is identical either way.

Test Plan:
- Reset, then port 0 read addr=0x00000000, MEM_LAT=1, RAM[0]=0x00500293 -> gnt[0] at t+1, mem_en one cycle, done[0] at t+3 with rdata=0x00500293.
- Port 2 writes 0x00000001/2/3 to addr 0x10/0x11/0x12, then port 1 reads 0x11 -> three write done pulses with no rdata change; the read returns 0x00000002.
- All three req held high for 9 transactions (feature off) -> grant sequence 0,1,2,0,1,2,0,1,2; no overlapping gnt; busy low only for one IDLE cycle between each.
- MEM_LAT=3, port 1 read of 0x30 holding 0x00000006 -> done[1] exactly 5 cycles after req sampled, rdata=0x00000006.
- rst pulsed during WAIT of a port 0 read -> no done[0]; all outputs zero (owner=2) the next cycle; a fresh port 0 request afterwards completes normally.
- ARB_DEBUG_PRIO_EN defined, req=3'b111 held -> port 2 granted every transaction until req[2] drops, then ports 0,1 alternate starting at 0.

Source files
------------

// File: rtl/mem_arbiter.sv
// Single-owner round-robin arbiter serialising fetch, load/store and debug ports onto one fixed-latency RAM.
// Optional ARB_DEBUG_PRIO_EN: port 2 gets absolute priority; ports 0/1 round-robin on their own pointer.
module mem_arbiter #(
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter int MEM_LAT = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [2:0]      req,
  input  logic [2:0]      we,
  input  logic [3*AW-1:0] addr,
  input  logic [3*DW-1:0] wdata,
  output logic [2:0]      gnt,
  output logic [2:0]      done,
  output logic [DW-1:0]   rdata,
  output logic            busy,
  output logic [1:0]      owner,
  output logic            mem_en,
  output logic            mem_we,
  output logic [AW-1:0]   mem_addr,
  output logic [DW-1:0]   mem_wdata,
  input  logic [DW-1:0]   mem_rdata
);

  if (MEM_LAT < 1 || MEM_LAT > 15) begin : g_lat_check
    $error("mem_arbiter: MEM_LAT must be within 1..15");
  end

  localparam logic [3:0] LAT_INIT = 4'(MEM_LAT);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ACCESS,
    S_WAIT,
    S_RESP
  } state_t;

  state_t        state;
  state_t        state_nxt;
  logic [3:0]    lat_cnt;
  logic          lat_we;
  logic [1:0]    winner;
  logic          win_valid;
  logic [AW-1:0] port_addr  [3];
  logic [DW-1:0] port_wdata [3];

`ifdef ARB_DEBUG_PRIO_EN
  // Last of ports 0/1 to be granted; debug grants leave it untouched.
  logic rr01_last;
`endif

  for (genvar i = 0; i < 3; i++) begin : g_unpack
    assign port_addr[i]  = addr[i*AW +: AW];
    assign port_wdata[i] = wdata[i*DW +: DW];
  end

  // Winner search starts one past the previous owner.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path can infer a latch.
    winner    = owner;
    win_valid = |req;
`ifdef ARB_DEBUG_PRIO_EN
    if (req[2])
      winner = 2'd2;
    else if (req[0] && req[1])
      winner = rr01_last ? 2'd0 : 2'd1;
    else if (req[1])
      winner = 2'd1;
    else
      winner = 2'd0;
`else
    case (owner)
      2'd0:    winner = req[1] ? 2'd1 : (req[2] ? 2'd2 : 2'd0);
      2'd1:    winner = req[2] ? 2'd2 : (req[0] ? 2'd0 : 2'd1);
      default: winner = req[0] ? 2'd0 : (req[1] ? 2'd1 : 2'd2);
    endcase
`endif
  end

  always_comb begin
    state_nxt = state;
    gnt       = 3'b000;
    done      = 3'b000;
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    busy      = (state != S_IDLE);
    case (state)
      S_IDLE: begin
        if (win_valid) state_nxt = S_ACCESS;
      end
      S_ACCESS: begin
        mem_en    = 1'b1;
        mem_we    = lat_we;
        gnt       = 3'b001 << owner;
        state_nxt = S_WAIT;
      end
      S_WAIT: begin
        if (lat_cnt == 4'd1) state_nxt = S_RESP;
      end
      S_RESP: begin
        done      = 3'b001 << owner;
        state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (rst) begin
      state     <= S_IDLE;
      owner     <= 2'd2;
      lat_cnt   <= 4'd0;
      lat_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      rdata     <= '0;
`ifdef ARB_DEBUG_PRIO_EN
      rr01_last <= 1'b1;
`endif
    end else begin
      state <= state_nxt;
      case (state)
        S_IDLE: begin
          if (win_valid) begin
            owner     <= winner;
            lat_we    <= we[winner];
            mem_addr  <= port_addr[winner];
            mem_wdata <= port_wdata[winner];
`ifdef ARB_DEBUG_PRIO_EN
            if (winner != 2'd2) rr01_last <= winner[0];
`endif
          end
        end
        S_ACCESS: lat_cnt <= LAT_INIT;
        S_WAIT: begin
          lat_cnt <= lat_cnt - 4'd1;
          // RAM data is valid in the last wait cycle; writes keep the previous read value.
          if (lat_cnt == 4'd1 && !lat_we) rdata <= mem_rdata;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed scenarios on MEM_LAT=1 and MEM_LAT=3 instances plus
// randomized traffic against a transaction-timeline reference model.
module tb_mem_arbiter;
  localparam int AW    = 32;
  localparam int DW    = 32;
  localparam int LAT_A = 1;
  localparam int LAT_B = 3;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [2:0]      req, we, gnt, done;
  logic [3*AW-1:0] addr;
  logic [3*DW-1:0] wdata;
  logic [DW-1:0]   rdata, mem_wdata, mem_rdata;
  logic            busy, mem_en, mem_we;
  logic [1:0]      owner;
  logic [AW-1:0]   mem_addr;

  logic [2:0]      l3_req, l3_we, l3_gnt, l3_done;
  logic [3*AW-1:0] l3_addr;
  logic [3*DW-1:0] l3_wdata;
  logic [DW-1:0]   l3_rdata, l3_mem_wdata, l3_mem_rdata;
  logic            l3_busy, l3_mem_en, l3_mem_we;
  logic [1:0]      l3_owner;
  logic [AW-1:0]   l3_mem_addr;

  int errors = 0;
  int checks = 0;

  mem_arbiter #(.AW(AW), .DW(DW), .MEM_LAT(LAT_A)) dut (
    .clk(clk), .rst(rst), .req(req), .we(we), .addr(addr), .wdata(wdata),
    .gnt(gnt), .done(done), .rdata(rdata), .busy(busy), .owner(owner),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  mem_arbiter #(.AW(AW), .DW(DW), .MEM_LAT(LAT_B)) dut3 (
    .clk(clk), .rst(rst), .req(l3_req), .we(l3_we), .addr(l3_addr), .wdata(l3_wdata),
    .gnt(l3_gnt), .done(l3_done), .rdata(l3_rdata), .busy(l3_busy), .owner(l3_owner),
    .mem_en(l3_mem_en), .mem_we(l3_mem_we), .mem_addr(l3_mem_addr), .mem_wdata(l3_mem_wdata),
    .mem_rdata(l3_mem_rdata)
  );

  // Behavioural RAMs: read data appears exactly LAT cycles after the strobe, garbage otherwise.
  logic [31:0] ram_a [256];
  logic [31:0] ram_b [256];
  logic [31:0] ref_mem [256];
  logic [31:0] pipe_a;
  logic [31:0] pipe_b [3];

  always @(posedge clk) begin
    if (mem_en && mem_we) ram_a[mem_addr[7:0]] = mem_wdata;
    pipe_a <= (mem_en && !mem_we) ? ram_a[mem_addr[7:0]] : 32'hdead_beef;
  end
  assign mem_rdata = pipe_a;

  always @(posedge clk) begin
    if (l3_mem_en && l3_mem_we) ram_b[l3_mem_addr[7:0]] = l3_mem_wdata;
    pipe_b[0] <= (l3_mem_en && !l3_mem_we) ? ram_b[l3_mem_addr[7:0]] : 32'hdead_beef;
    pipe_b[1] <= pipe_b[0];
    pipe_b[2] <= pipe_b[1];
  end
  assign l3_mem_rdata = pipe_b[2];

  function automatic logic [31:0] pat(input int i);
    return {8'hA5, 8'(i), 8'(255 - i), 8'(i * 7)};
  endfunction

  task automatic init_mems();
    for (int i = 0; i < 256; i++) begin
      ram_a[i]   = pat(i);
      ram_b[i]   = pat(i);
      ref_mem[i] = pat(i);
    end
    ram_a[0]     = 32'h0050_0293;
    ref_mem[0]   = 32'h0050_0293;
    ram_b[8'h30] = 32'h0000_0006;
  endtask

  task automatic drive(input int p, input logic r, input logic w, input logic [AW-1:0] a,
                       input logic [DW-1:0] d);
    req[p]            = r;
    we[p]             = w;
    addr[p*AW +: AW]  = a;
    wdata[p*DW +: DW] = d;
  endtask

  // Issues one request on the MEM_LAT=1 instance; returns cycle offsets of gnt/done (-1 if never seen).
  task automatic run_one(input int p, input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d,
                         output int gnt_at, output int done_at, output int en_cnt,
                         output logic [DW-1:0] rd);
    gnt_at  = -1;
    done_at = -1;
    en_cnt  = 0;
    rd      = 'x;
    drive(p, 1'b1, w, a, d);
    for (int k = 1; k <= 30; k++) begin
      @(negedge clk);
      if (mem_en) en_cnt++;
      if (gnt[p] && gnt_at < 0) begin
        gnt_at = k;
        drive(p, 1'b0, 1'b0, '0, '0);
      end
      if (done[p]) begin
        done_at = k;
        rd      = rdata;
        break;
      end
    end
    drive(p, 1'b0, 1'b0, '0, '0);
    @(negedge clk);
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    checks++; if (gnt !== 3'b000) begin errors++; $display("FAIL reset_gnt: got %b want 000", gnt); end
    checks++; if (done !== 3'b000) begin errors++; $display("FAIL reset_done: got %b want 000", done); end
    checks++; if (rdata !== 32'h0) begin errors++; $display("FAIL reset_rdata: got %h want 0", rdata); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
    checks++; if (owner !== 2'd2) begin errors++; $display("FAIL reset_owner: got %0d want 2", owner); end
    checks++; if ({mem_en, mem_we} !== 2'b00) begin errors++; $display("FAIL reset_mem_ctl: got %b want 00", {mem_en, mem_we}); end
    checks++; if ({mem_addr, mem_wdata} !== 64'h0) begin errors++; $display("FAIL reset_mem_bus: got %h want 0", {mem_addr, mem_wdata}); end
    checks++; if (l3_owner !== 2'd2 || l3_busy !== 1'b0) begin errors++; $display("FAIL reset_l3: got owner=%0d busy=%b want 2/0", l3_owner, l3_busy); end
    rst = 1'b0;
    @(negedge clk);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL idle_after_reset: got busy=%b want 0", busy); end
  endtask

  task automatic test_fetch_read();
    int g, d, en;
    logic [DW-1:0] rd;
    run_one(0, 1'b0, 32'h0, 32'h0, g, d, en, rd);
    checks++; if (g !== 1) begin errors++; $display("FAIL fetch_gnt_at: got %0d want 1", g); end
    checks++; if (d !== 3) begin errors++; $display("FAIL fetch_done_at: got %0d want 3", d); end
    checks++; if (en !== 1) begin errors++; $display("FAIL fetch_mem_en_cycles: got %0d want 1", en); end
    checks++; if (rd !== 32'h0050_0293) begin errors++; $display("FAIL fetch_rdata: got %h want 00500293", rd); end
  endtask

  task automatic test_write_then_read();
    int g, d, en;
    logic [DW-1:0] rd;
    for (int i = 0; i < 3; i++) begin
      run_one(2, 1'b1, 32'h10 + 32'(i), 32'(i + 1), g, d, en, rd);
      checks++; if (d !== 3) begin errors++; $display("FAIL write%0d_done_at: got %0d want 3", i, d); end
      checks++; if (rd !== 32'h0050_0293) begin errors++; $display("FAIL write%0d_rdata_held: got %h want 00500293", i, rd); end
    end
    run_one(1, 1'b0, 32'h11, 32'h0, g, d, en, rd);
    checks++; if (rd !== 32'h0000_0002) begin errors++; $display("FAIL readback_0x11: got %h want 00000002", rd); end
  endtask

`ifndef ARB_DEBUG_PRIO_EN
  task automatic test_fairness();
    int n_gnt, last_at, idle_cnt, overlap;
    logic [2:0] exp_g;
    n_gnt = 0; last_at = 0; idle_cnt = 0; overlap = 0;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 3; i++) drive(i, 1'b1, 1'b0, 32'h40 + 32'(i), 32'h0);
    for (int k = 1; k <= 200; k++) begin
      @(negedge clk);
      if (gnt !== 3'b000 && done !== 3'b000) overlap++;
      if (gnt !== 3'b000) begin
        exp_g = 3'(1 << (n_gnt % 3));
        checks++; if (gnt !== exp_g) begin errors++; $display("FAIL rr_order[%0d]: got %b want %b", n_gnt, gnt, exp_g); end
        if (n_gnt > 0) begin
          checks++; if (k - last_at !== LAT_A + 3) begin errors++; $display("FAIL rr_spacing[%0d]: got %0d want %0d", n_gnt, k - last_at, LAT_A + 3); end
        end
        last_at = k;
        n_gnt++;
        if (n_gnt == 9) begin
          req = 3'b000;
          break;
        end
      end
      if (n_gnt >= 1 && !busy) idle_cnt++;
    end
    repeat (LAT_A + 3) @(negedge clk);
    checks++; if (n_gnt !== 9) begin errors++; $display("FAIL rr_grant_count: got %0d want 9", n_gnt); end
    checks++; if (idle_cnt !== 8) begin errors++; $display("FAIL rr_idle_cycles: got %0d want 8", idle_cnt); end
    checks++; if (overlap !== 0) begin errors++; $display("FAIL rr_gnt_done_overlap: got %0d want 0", overlap); end
  endtask
`else
  task automatic test_debug_prio();
    int n_gnt;
    logic [2:0] exp_seq [8];
    exp_seq = '{3'b100, 3'b100, 3'b100, 3'b100, 3'b001, 3'b010, 3'b001, 3'b010};
    n_gnt = 0;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 3; i++) drive(i, 1'b1, 1'b0, 32'h50 + 32'(i), 32'h0);
    for (int k = 1; k <= 200 && n_gnt < 8; k++) begin
      @(negedge clk);
      if (gnt !== 3'b000) begin
        checks++; if (gnt !== exp_seq[n_gnt]) begin errors++; $display("FAIL prio_order[%0d]: got %b want %b", n_gnt, gnt, exp_seq[n_gnt]); end
        n_gnt++;
        if (n_gnt == 4) drive(2, 1'b0, 1'b0, '0, '0);
      end
    end
    req = 3'b000;
    repeat (LAT_A + 3) @(negedge clk);
    checks++; if (n_gnt !== 8) begin errors++; $display("FAIL prio_grant_count: got %0d want 8", n_gnt); end
  endtask
`endif

  task automatic test_latency3();
    int g, d;
    logic [DW-1:0] rd;
    g = -1; d = -1; rd = 'x;
    l3_req[1] = 1'b1; l3_we[1] = 1'b0; l3_addr[AW +: AW] = 32'h30;
    for (int k = 1; k <= 30; k++) begin
      @(negedge clk);
      if (l3_gnt[1] && g < 0) begin
        g = k;
        l3_req[1] = 1'b0;
      end
      if (l3_done[1]) begin
        d  = k;
        rd = l3_rdata;
        break;
      end
    end
    l3_req = 3'b000;
    @(negedge clk);
    checks++; if (g !== 1) begin errors++; $display("FAIL lat3_gnt_at: got %0d want 1", g); end
    checks++; if (d !== 5) begin errors++; $display("FAIL lat3_done_at: got %0d want 5", d); end
    checks++; if (rd !== 32'h0000_0006) begin errors++; $display("FAIL lat3_rdata: got %h want 00000006", rd); end
  endtask

  task automatic test_reset_mid_wait();
    int g, d, en, stray;
    logic [DW-1:0] rd;
    stray = 0;
    drive(0, 1'b1, 1'b0, 32'h5, 32'h0);
    @(negedge clk);
    checks++; if (gnt !== 3'b001) begin errors++; $display("FAIL rstwait_gnt: got %b want 001", gnt); end
    drive(0, 1'b0, 1'b0, '0, '0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    checks++; if (done !== 3'b000) begin errors++; $display("FAIL rstwait_done: got %b want 000", done); end
    checks++; if ({gnt, busy, mem_en, mem_we} !== 6'b0) begin errors++; $display("FAIL rstwait_ctl: got %b want 0", {gnt, busy, mem_en, mem_we}); end
    checks++; if (owner !== 2'd2) begin errors++; $display("FAIL rstwait_owner: got %0d want 2", owner); end
    checks++; if ({rdata, mem_addr, mem_wdata} !== 96'h0) begin errors++; $display("FAIL rstwait_data: got %h want 0", {rdata, mem_addr, mem_wdata}); end
    rst = 1'b0;
    repeat (3) begin
      @(negedge clk);
      if (done !== 3'b000) stray++;
    end
    checks++; if (stray !== 0) begin errors++; $display("FAIL rstwait_stray_done: got %0d want 0", stray); end
    run_one(0, 1'b0, 32'h5, 32'h0, g, d, en, rd);
    checks++; if (d !== 3) begin errors++; $display("FAIL rstwait_fresh_done_at: got %0d want 3", d); end
    checks++; if (rd !== pat(5)) begin errors++; $display("FAIL rstwait_fresh_rdata: got %h want %h", rd, pat(5)); end
  endtask

  // Reference model state: transaction timeline and arbitration pointers.
  int m_owner;
  int m_last01;

  function automatic int pick(input logic [2:0] r);
`ifdef ARB_DEBUG_PRIO_EN
    if (r[2]) return 2;
    if (r[0] && r[1]) return (m_last01 == 0) ? 1 : 0;
    return r[0] ? 0 : 1;
`else
    for (int k = 1; k <= 3; k++)
      if (r[(m_owner + k) % 3]) return (m_owner + k) % 3;
    return -1;
`endif
  endfunction

  task automatic test_random();
    int next_sample, e_gnt_c, e_done_c, e_port, w;
    logic e_we;
    logic [AW-1:0] e_addr;
    logic [DW-1:0] e_wdata, e_rd, exp_rdata;
    logic [2:0] exp_gnt, exp_done, p_pend;
    logic [2:0] pw;
    logic [AW-1:0] pa [3];
    logic [DW-1:0] pd [3];
    rst = 1'b1;
    req = '0; we = '0; addr = '0; wdata = '0;
    init_mems();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    m_owner = 2; m_last01 = 1;
    next_sample = 0; e_gnt_c = -1; e_done_c = -1; e_port = 0;
    e_we = 1'b0; e_addr = '0; e_wdata = '0; e_rd = '0; exp_rdata = '0;
    p_pend = '0; pw = '0;
    for (int i = 0; i < 3; i++) begin pa[i] = '0; pd[i] = '0; end
    for (int c = 0; c < 800; c++) begin
      exp_gnt  = (c == e_gnt_c)  ? 3'(1 << e_port) : 3'b000;
      exp_done = (c == e_done_c) ? 3'(1 << e_port) : 3'b000;
      if (c == e_done_c && !e_we) exp_rdata = e_rd;
      checks++; if (gnt !== exp_gnt) begin errors++; $display("FAIL rand_gnt c=%0d: got %b want %b", c, gnt, exp_gnt); end
      checks++; if (done !== exp_done) begin errors++; $display("FAIL rand_done c=%0d: got %b want %b", c, done, exp_done); end
      checks++; if (rdata !== exp_rdata) begin errors++; $display("FAIL rand_rdata c=%0d: got %h want %h", c, rdata, exp_rdata); end
      checks++; if (busy !== (c < next_sample)) begin errors++; $display("FAIL rand_busy c=%0d: got %b want %b", c, busy, c < next_sample); end
      checks++; if (owner !== 2'(m_owner)) begin errors++; $display("FAIL rand_owner c=%0d: got %0d want %0d", c, owner, m_owner); end
      checks++; if (mem_en !== (c == e_gnt_c) || mem_we !== ((c == e_gnt_c) && e_we)) begin
        errors++; $display("FAIL rand_mem_ctl c=%0d: got en=%b we=%b want en=%b we=%b", c, mem_en, mem_we, c == e_gnt_c, (c == e_gnt_c) && e_we);
      end
      if (c == e_gnt_c) begin
        checks++; if (mem_addr !== e_addr) begin errors++; $display("FAIL rand_mem_addr c=%0d: got %h want %h", c, mem_addr, e_addr); end
        if (e_we) begin
          checks++; if (mem_wdata !== e_wdata) begin errors++; $display("FAIL rand_mem_wdata c=%0d: got %h want %h", c, mem_wdata, e_wdata); end
        end
      end
      // Requesters: hold until granted, occasionally withdraw, re-request at random.
      for (int i = 0; i < 3; i++) begin
        if (gnt[i]) p_pend[i] = 1'b0;
        else if (p_pend[i] && $urandom_range(0, 15) == 0) p_pend[i] = 1'b0;
        if (!p_pend[i]) begin
          p_pend[i] = ($urandom_range(0, 2) == 0);
          pw[i]     = 1'($urandom_range(0, 1));
          pa[i]     = {24'($urandom()), 4'h0, 4'($urandom_range(0, 15))};
          pd[i]     = $urandom();
        end
        drive(i, p_pend[i], pw[i], pa[i], pd[i]);
      end
      if (c >= next_sample) begin
        if (req != 3'b000) begin
          w        = pick(req);
          e_port   = w;
          e_we     = we[w];
          e_addr   = pa[w];
          e_wdata  = pd[w];
          e_rd     = ref_mem[e_addr[7:0]];
          if (e_we) ref_mem[e_addr[7:0]] = e_wdata;
          e_gnt_c  = c + 1;
          e_done_c = c + 2 + LAT_A;
          next_sample = c + 3 + LAT_A;
          m_owner  = w;
          if (w < 2) m_last01 = w;
        end else begin
          next_sample = c + 1;
        end
      end
      @(negedge clk);
    end
    req = 3'b000;
    repeat (LAT_A + 4) @(negedge clk);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    req = '0; we = '0; addr = '0; wdata = '0;
    l3_req = '0; l3_we = '0; l3_addr = '0; l3_wdata = '0;
    init_mems();
    test_reset();
    test_fetch_read();
    test_write_then_read();
`ifdef ARB_DEBUG_PRIO_EN
    test_debug_prio();
`else
    test_fairness();
`endif
    test_latency3();
    test_reset_mid_wait();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
